// File: rtl/rv32i_storebuffer_if.sv
// Data-memory write port between the store buffer and data memory.
// The store buffer offers one word-aligned write at a time; memory accepts it with MemReady.
interface rv32i_storebuffer_if;
  logic        MemWE;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [3:0]  MemBE;
  logic        MemReady;

  modport master (output MemWE, MemAddr, MemWData, MemBE, input MemReady);
  modport slave  (input MemWE, MemAddr, MemWData, MemBE, output MemReady);
endinterface

// File: rtl/rv32i_storebuffer.sv
// RV32I memory-stage store buffer: converts stores to aligned word writes with byte enables,
// queues them in a FIFO, drains them in order and stalls on full or on a load that hits a pending store.
module rv32i_storebuffer #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [1:0]  StoreSizeM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        StallSB,
  output logic        StoreFault,
  output logic        SBEmpty,
  rv32i_storebuffer_if.master memPort
);

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } sbEntry_t;

  sbEntry_t         entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTRW-1:0]  head;
  logic [PTRW-1:0]  tail;
  logic [PTRW:0]    count;

  logic [1:0]  byteOff;
  logic [31:0] storeData;
  logic [3:0]  storeBE;
  logic        misaligned;
  logic        full;
  logic        enq;
  logic        deq;
  logic        hit;

  assign byteOff = ALUResultM[1:0];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    storeData  = WriteDataM;
    storeBE    = 4'b1111;
    misaligned = 1'b0;
    case (StoreSizeM)
      2'b00: begin
        storeData = {4{WriteDataM[7:0]}};
        storeBE   = 4'b0001 << byteOff;
      end
      2'b01: begin
        storeData  = {2{WriteDataM[15:0]}};
        storeBE    = 4'b0011 << byteOff;
        misaligned = byteOff[0];
      end
      default: misaligned = (byteOff != 2'b00);
    endcase
  end

  // Full is judged on the registered count, so a same-cycle drain never frees a slot early.
  assign full    = (count == (PTRW + 1)'(DEPTH));
  assign SBEmpty = (count == '0);
  assign enq     = MemWriteM & ~misaligned & ~full;
  assign deq     = memPort.MemWE & memPort.MemReady;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i].addr == ALUResultM[31:2])) hit = 1'b1;
    end
  end

  assign StallSB = (MemWriteM & ~misaligned & full) | (MemReadM & hit);

  assign memPort.MemWE    = ~SBEmpty;
  assign memPort.MemAddr  = SBEmpty ? '0 : {entries[head].addr, 2'b00};
  assign memPort.MemWData = SBEmpty ? '0 : entries[head].data;
  assign memPort.MemBE    = SBEmpty ? '0 : entries[head].be;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      valid      <= '0;
      StoreFault <= 1'b0;
    end else begin
      StoreFault <= MemWriteM & misaligned;
      if (enq) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (deq) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the entry storage is not reset; the valid bits and count decide what is live.
  always_ff @(posedge clk) begin
    if (enq) entries[tail] <= '{addr: ALUResultM[31:2], data: storeData, be: storeBE};
  end

endmodule

// File: tb/tb_rv32i_storebuffer.sv
// Directed bench for rv32i_storebuffer: reset, size conversion, backpressure, wrap-around,
// load hazard, misalignment and reset while a write is offered.
module tb_rv32i_storebuffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWriteM;
  logic        MemReadM;
  logic [1:0]  StoreSizeM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        StallSB;
  logic        StoreFault;
  logic        SBEmpty;

  int nChecks = 0;
  int nFails  = 0;

  logic [31:0] wrLog [$];

  rv32i_storebuffer_if memBus ();

  rv32i_storebuffer #(.DEPTH(4), .PTRW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemWriteM  (MemWriteM),
    .MemReadM   (MemReadM),
    .StoreSizeM (StoreSizeM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .StallSB    (StallSB),
    .StoreFault (StoreFault),
    .SBEmpty    (SBEmpty),
    .memPort    (memBus)
  );

  always #5 clk = ~clk;

  // Inputs only change 1 time unit after a rising edge, so a negedge sample predicts the next transfer.
  always @(negedge clk) begin
    if (!rst && memBus.MemWE && memBus.MemReady) wrLog.push_back(memBus.MemAddr);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] data);
    MemWriteM  = 1'b1;
    StoreSizeM = sz;
    ALUResultM = addr;
    WriteDataM = data;
  endtask

  initial begin
    // Reset held for two edges while a store is presented.
    rst = 1'b1;
    MemReadM = 1'b0;
    memBus.MemReady = 1'b1;
    store(2'b10, 32'h0000_0040, 32'hCAFE_F00D);
    tick();
    tick();
    check("rst_empty", 32'(SBEmpty), 32'd1);
    check("rst_we", 32'(memBus.MemWE), 32'd0);
    check("rst_addr", memBus.MemAddr, 32'h0);
    check("rst_wdata", memBus.MemWData, 32'h0);
    check("rst_be", 32'(memBus.MemBE), 32'h0);
    check("rst_stall", 32'(StallSB), 32'd0);
    check("rst_fault", 32'(StoreFault), 32'd0);
    rst = 1'b0;
    MemWriteM = 1'b0;
    tick();
    check("rst_nothing_enq", 32'(SBEmpty), 32'd1);

    // Byte and half conversion with memory always ready.
    store(2'b00, 32'h0000_1003, 32'h1234_56A5);
    tick();
    MemWriteM = 1'b0;
    check("byte_we", 32'(memBus.MemWE), 32'd1);
    check("byte_addr", memBus.MemAddr, 32'h0000_1000);
    check("byte_wdata", memBus.MemWData, 32'hA5A5_A5A5);
    check("byte_be", 32'(memBus.MemBE), 32'h8);
    store(2'b01, 32'h0000_2002, 32'h0000_BEEF);
    tick();
    MemWriteM = 1'b0;
    check("half_addr", memBus.MemAddr, 32'h0000_2000);
    check("half_wdata", memBus.MemWData, 32'hBEEF_BEEF);
    check("half_be", 32'(memBus.MemBE), 32'hC);
    tick();
    check("half_drained", 32'(SBEmpty), 32'd1);
    check("empty_addr", memBus.MemAddr, 32'h0);

    // Fill to DEPTH under backpressure, then release.
    wrLog.delete();
    memBus.MemReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      store(2'b10, 32'h100 + 32'(4 * i), 32'hD0 + 32'(i));
      check("fill_nostall", 32'(StallSB), 32'd0);
      tick();
    end
    store(2'b10, 32'h0000_0110, 32'h0000_00D4);
    check("full_stall", 32'(StallSB), 32'd1);
    check("full_head", memBus.MemAddr, 32'h0000_0100);
    tick();
    check("full_hold_head", memBus.MemAddr, 32'h0000_0100);
    check("full_hold_stall", 32'(StallSB), 32'd1);
    memBus.MemReady = 1'b1;
    check("full_stall_on_drain", 32'(StallSB), 32'd1);
    tick();
    check("after_drain_head", memBus.MemAddr, 32'h0000_0104);
    check("after_drain_stall", 32'(StallSB), 32'd0);
    tick();
    MemWriteM = 1'b0;
    check("drain_head_108", memBus.MemAddr, 32'h0000_0108);
    tick();
    check("drain_head_10c", memBus.MemAddr, 32'h0000_010C);
    tick();
    check("drain_head_110", memBus.MemAddr, 32'h0000_0110);
    check("drain_data_110", memBus.MemWData, 32'h0000_00D4);
    tick();
    check("fill_drained", 32'(SBEmpty), 32'd1);
    check("fill_log_size", 32'(wrLog.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < wrLog.size()) check("fill_order", wrLog[i], 32'h100 + 32'(4 * i));
    end

    // Steady enqueue+dequeue at count 2; eight stores wrap the pointers twice.
    memBus.MemReady = 1'b0;
    store(2'b10, 32'h0000_0400, 32'd0);
    tick();
    store(2'b10, 32'h0000_0404, 32'd1);
    tick();
    memBus.MemReady = 1'b1;
    for (int k = 2; k < 8; k++) begin
      store(2'b10, 32'h400 + 32'(4 * k), 32'(k));
      check("steady_nostall", 32'(StallSB), 32'd0);
      tick();
      check("steady_head", memBus.MemAddr, 32'h400 + 32'(4 * (k - 1)));
    end
    MemWriteM = 1'b0;
    tick();
    check("steady_last_head", memBus.MemAddr, 32'h0000_041C);
    check("steady_last_data", memBus.MemWData, 32'd7);
    tick();
    check("steady_count2_drained", 32'(SBEmpty), 32'd1);

    // Load hazard against a pending store.
    memBus.MemReady = 1'b0;
    store(2'b10, 32'h0000_0200, 32'h0000_0055);
    tick();
    MemWriteM  = 1'b0;
    MemReadM   = 1'b1;
    ALUResultM = 32'h0000_0202;
    #1;
    check("hazard_hit", 32'(StallSB), 32'd1);
    ALUResultM = 32'h0000_0204;
    #1;
    check("hazard_other_word", 32'(StallSB), 32'd0);
    ALUResultM = 32'h0000_0202;
    tick();
    check("hazard_held", 32'(StallSB), 32'd1);
    memBus.MemReady = 1'b1;
    #1;
    check("hazard_until_drain", 32'(StallSB), 32'd1);
    tick();
    check("hazard_released", 32'(StallSB), 32'd0);
    check("hazard_empty", 32'(SBEmpty), 32'd1);
    MemReadM = 1'b0;

    // Misaligned word and half stores are dropped with a one-cycle fault.
    store(2'b10, 32'h0000_0301, 32'h1111_1111);
    #1;
    check("mis_word_nostall", 32'(StallSB), 32'd0);
    tick();
    MemWriteM = 1'b0;
    check("mis_word_fault", 32'(StoreFault), 32'd1);
    check("mis_word_empty", 32'(SBEmpty), 32'd1);
    check("mis_word_we", 32'(memBus.MemWE), 32'd0);
    tick();
    check("mis_word_fault_clr", 32'(StoreFault), 32'd0);
    store(2'b01, 32'h0000_0303, 32'h2222_2222);
    #1;
    check("mis_half_nostall", 32'(StallSB), 32'd0);
    tick();
    MemWriteM = 1'b0;
    check("mis_half_fault", 32'(StoreFault), 32'd1);
    check("mis_half_empty", 32'(SBEmpty), 32'd1);
    tick();
    check("mis_half_fault_clr", 32'(StoreFault), 32'd0);

    // Reset while a write is offered with MemReady high discards it.
    store(2'b10, 32'h0000_0500, 32'h0000_0077);
    tick();
    MemWriteM = 1'b0;
    check("midrst_offer", 32'(memBus.MemWE), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_empty", 32'(SBEmpty), 32'd1);
    check("midrst_we", 32'(memBus.MemWE), 32'd0);
    check("midrst_addr", memBus.MemAddr, 32'h0);
    tick();
    check("midrst_stays_empty", 32'(SBEmpty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
